// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared definitions for the multicycle divider.
//   div_state_e   - divider FSM states (DivFree/DivByZero/DivOn/DivEnd)
//   DivResult*    - ready_o levels
//   DivStart/Stop - start_i levels
//   EXE_OP_DIV*   - EX-stage aluop codes that route to this unit
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [7:0] EXE_OP_DIV  = 8'b0001_1010;
  localparam logic [7:0] EXE_OP_DIVU = 8'b0001_1011;

endpackage

// File: rtl/div_unit.sv
// div_unit: multicycle restoring divider for DIV/DIVU, one quotient bit per
// cycle. Responder side of a start/ready handshake with the EX stage.
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   signed_div_i   1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i      dividend
//   opdata2_i      divisor
//   start_i        request, held high until ready_o is seen
//   annul_i        abort (pipeline flush)
//   result_o       {remainder, quotient}, registered
//   ready_o        result_o valid, registered
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  div_state_e             r_state, w_state_nxt;
  logic [2*DATA_W:0]      r_work, w_work_nxt;
  logic [DATA_W-1:0]      r_divisor, w_divisor_nxt;
  logic                   r_neg_dvd, w_neg_dvd_nxt;
  logic                   r_neg_dvs, w_neg_dvs_nxt;
  logic                   r_signed, w_signed_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [2*DATA_W-1:0]    r_result, w_result_nxt;
  logic                   r_ready, w_ready_nxt;

  logic [DATA_W-1:0]      w_abs_dvd, w_abs_dvs;
  logic [DATA_W:0]        w_diff;
  logic [DATA_W-1:0]      w_quot, w_rem, w_quot_fix, w_rem_fix;

  assign w_abs_dvd = (signed_div_i && opdata1_i[DATA_W-1]) ? ('0 - opdata1_i) : opdata1_i;
  assign w_abs_dvs = (signed_div_i && opdata2_i[DATA_W-1]) ? ('0 - opdata2_i) : opdata2_i;

  // 33-bit trial subtract; bit DATA_W set means the partial remainder is
  // smaller than the divisor.
  assign w_diff = {1'b0, r_work[2*DATA_W-1:DATA_W]} - {1'b0, r_divisor};

  // Quotient bits accumulate at the bottom, remainder lands one bit above
  // the middle because the dividend is loaded pre-shifted by one.
  assign w_quot = r_work[DATA_W-1:0];
  assign w_rem  = r_work[2*DATA_W:DATA_W+1];

  assign w_quot_fix = (r_signed && (r_neg_dvd ^ r_neg_dvs)) ? ('0 - w_quot) : w_quot;
  assign w_rem_fix  = (r_signed && r_neg_dvd) ? ('0 - w_rem) : w_rem;

  always_comb begin
    w_state_nxt   = r_state;
    w_work_nxt    = r_work;
    w_divisor_nxt = r_divisor;
    w_neg_dvd_nxt = r_neg_dvd;
    w_neg_dvs_nxt = r_neg_dvs;
    w_signed_nxt  = r_signed;
    w_cnt_nxt     = r_cnt;
    w_result_nxt  = r_result;
    w_ready_nxt   = r_ready;

    unique case (r_state)
      DivFree: begin
        w_result_nxt = '0;
        w_ready_nxt  = DivResultNotReady;
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            w_state_nxt = DivByZero;
          end else begin
            w_state_nxt   = DivOn;
            // Dividend sits one bit up so the first trial subtract already
            // sees its MSB; 32 steps then consume every dividend bit.
            w_work_nxt    = {{DATA_W{1'b0}}, w_abs_dvd, 1'b0};
            w_divisor_nxt = w_abs_dvs;
            w_neg_dvd_nxt = opdata1_i[DATA_W-1];
            w_neg_dvs_nxt = opdata2_i[DATA_W-1];
            w_signed_nxt  = signed_div_i;
            w_cnt_nxt     = '0;
          end
        end
      end

      DivByZero: begin
        w_state_nxt  = DivEnd;
        w_work_nxt   = '0;
        w_result_nxt = '0;
        w_ready_nxt  = DivResultReady;
      end

      DivOn: begin
        if (annul_i) begin
          w_state_nxt  = DivFree;
          w_result_nxt = '0;
          w_ready_nxt  = DivResultNotReady;
        end else if (r_cnt == CNT_W'(DATA_W)) begin
          w_state_nxt  = DivEnd;
          w_result_nxt = {w_rem_fix, w_quot_fix};
          w_ready_nxt  = DivResultReady;
        end else begin
          if (w_diff[DATA_W]) begin
            w_work_nxt = {r_work[2*DATA_W-1:0], 1'b0};
          end else begin
            w_work_nxt = {w_diff[DATA_W-1:0], r_work[DATA_W-1:0], 1'b1};
          end
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      DivEnd: begin
        if (start_i == DivStop || annul_i) begin
          w_state_nxt  = DivFree;
          w_result_nxt = '0;
          w_ready_nxt  = DivResultNotReady;
        end
      end

      default: w_state_nxt = DivFree;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= DivFree;
      r_work    <= '0;
      r_divisor <= '0;
      r_neg_dvd <= 1'b0;
      r_neg_dvs <= 1'b0;
      r_signed  <= 1'b0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_ready   <= DivResultNotReady;
    end else begin
      r_state   <= w_state_nxt;
      r_work    <= w_work_nxt;
      r_divisor <= w_divisor_nxt;
      r_neg_dvd <= w_neg_dvd_nxt;
      r_neg_dvs <= w_neg_dvs_nxt;
      r_signed  <= w_signed_nxt;
      r_cnt     <= w_cnt_nxt;
      r_result  <= w_result_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit. The driver pushes the expected
// {remainder, quotient} and the cycle at which ready_o must rise; a monitor
// on the falling edge pops and compares on every ready_o rising edge, checks
// the result is held while ready_o stays high and is zero while it is low.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  typedef struct {
    logic [63:0] res;
    int unsigned cyc;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  int unsigned cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division with truncation toward zero; the
  // 64-bit intermediate makes -2^31 / -1 wrap naturally to 0x80000000.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor
  exp_t cur;
  bit   have_cur  = 0;
  bit   prev_rdy  = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_rdy = 0;
      have_cur = 0;
    end else begin
      if (ready_o) begin
        if (!prev_rdy) begin
          if (sb_q.size() == 0) begin
            check64("unexpected_ready", {63'd0, ready_o}, 64'd0);
            have_cur = 0;
          end else begin
            cur = sb_q.pop_front();
            have_cur = 1;
            check64("result", result_o, cur.res);
            check64("latency_cycle", 64'(cyc), 64'(cur.cyc));
          end
        end else if (have_cur) begin
          check64("result_hold", result_o, cur.res);
        end
      end else begin
        check64("idle_result_zero", result_o, 64'd0);
      end
      prev_rdy = ready_o;
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check64("ready_timeout", 64'd0, 64'd1);
  endtask

  // Issue one division; optionally scramble operands mod_at cycles in,
  // and hold start_i for 'hold' extra cycles after ready.
  task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input int unsigned hold, input int unsigned mod_at);
    exp_t e;
    bit   ok;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    e.res = ref_div(sgn, a, b);
    e.cyc = cyc + 1 + ((b == 32'd0) ? 1 : 33);
    sb_q.push_back(e);
    if (mod_at != 0) begin
      repeat (mod_at) @(negedge clk);
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = ~sgn;
    end
    wait_ready(ok);
    repeat (hold) @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bit ok;
    bit saw_rdy;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    #1;
    check64("reset_ready", {63'd0, ready_o}, 64'd0);
    check64("reset_result", result_o, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed cases
    do_div(1'b0, 32'd100, 32'd7, 0, 0);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 0);
    do_div(1'b1, 32'd1234, 32'd0, 0, 0);
    do_div(1'b0, 32'd1234, 32'd0, 0, 0);
    do_div(1'b0, 32'd100, 32'd7, 5, 0);
    do_div(1'b0, 32'd1000, 32'd3, 0, 12);
    do_div(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0);
    do_div(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 0, 0);

    // Annul at edge N+10: no ready, then a fresh division works
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd500;
    opdata2_i    = 32'd9;
    start_i      = 1'b1;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    saw_rdy = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) saw_rdy = 1;
    end
    check64("annul_no_ready", {63'd0, saw_rdy}, 64'd0);
    do_div(1'b0, 32'hFFFF_FFFF, 32'h10, 0, 0);

    // Async reset mid-DivOn, result discarded
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd77;
    opdata2_i    = 32'd5;
    start_i      = 1'b1;
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check64("rst_mid_on_ready", {63'd0, ready_o}, 64'd0);
    check64("rst_mid_on_result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);

    // Async reset while a result is being presented
    begin
      exp_t e;
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i    = 32'hDEAD_BEEF;
      opdata2_i    = 32'd13;
      start_i      = 1'b1;
      e.res = ref_div(1'b0, 32'hDEAD_BEEF, 32'd13);
      e.cyc = cyc + 34;
      sb_q.push_back(e);
      wait_ready(ok);
      #2 rst = 1'b1;
      #1;
      check64("rst_in_end_ready", {63'd0, ready_o}, 64'd0);
      check64("rst_in_end_result", result_o, 64'd0);
      start_i = 1'b0;
      @(negedge clk);
      #1 rst = 1'b0;
    end

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, b;
      int unsigned sel;
      a   = $urandom;
      sel = $urandom_range(0, 5);
      case (sel)
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 20);
        2:       b = 32'd0 - $urandom_range(1, 20);
        3:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if (sel == 5) a = $urandom_range(0, 1000);
      do_div(1'($urandom_range(0, 1)), a, b, $urandom_range(0, 3),
             ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : 0);
    end

    repeat (5) @(negedge clk);
    check64("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
